// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning stage.
package btn_pkg;

  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_LEFT  = 1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, stability counter, debounced level and edge pulses.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic press_next
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q, press_q, rls_q;
  logic            sync, mismatch, done;

  assign sync     = sync_q[1];
  assign mismatch = sync ^ level_q;
  assign done     = mismatch && (cnt_q == CntMax);

  // Lets the parent update registers on the same edge that raises press.
  assign press_next = done & sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rls_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      press_q <= done & sync;
      rls_q   <= done & ~sync;
      if (!mismatch || done) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done) begin
        level_q <= sync;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rls   = rls_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces NBTN push-buttons and keeps the barrel shifter direction bit
// (left button sets it, right button clears it).
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NBTN            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic            any_press,
  output logic            dir
);

  logic [NBTN-1:0] press_next;
  logic            any_press_q, dir_q;

  for (genvar i = 0; i < NBTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clock      (clock),
      .reset_n    (reset_n),
      .btn_raw    (btn_raw[i]),
      .level      (btn_level[i]),
      .press      (btn_press[i]),
      .rls        (btn_release[i]),
      .press_next (press_next[i])
    );
  end

  // Simultaneous left and right presses leave the direction unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      any_press_q <= 1'b0;
      dir_q       <= DIR_RIGHT;
    end else begin
      any_press_q <= |press_next;
      if (press_next[BTN_LEFT] && !press_next[BTN_RIGHT]) begin
        dir_q <= DIR_LEFT;
      end else if (press_next[BTN_RIGHT] && !press_next[BTN_LEFT]) begin
        dir_q <= DIR_RIGHT;
      end
    end
  end

  assign any_press = any_press_q;
  assign dir       = dir_q;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Upstream conditioning stage for the board's push-buttons (ssl/ssr and similar). It synchronises raw button pins to the system clock and debounces each one with a per-button stability counter. Outputs per button: a clean level, a one-cycle press pulse and a one-cycle release pulse. It also holds a registered shift-direction bit (set by the left button, cleared by the right), which drives the downstream barrel shifter's direction input directly.

Parameters:
NBTN, 2, number of buttons; must be >= 2; btn[0] = right (ssr), btn[1] = left (ssl).
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required (10 ms at 100 MHz); must be >= 2.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
btn_raw  in  NBTN  raw, asynchronous, bouncing button pins; active-high.
btn_level  out  NBTN  debounced button level.
btn_press  out  NBTN  one-cycle pulse on each debounced 0->1 transition.
btn_release  out  NBTN  one-cycle pulse on each debounced 1->0 transition.
any_press  out  1  OR of btn_press; shift-step strobe.
dir  out  1  shift direction; 1 = left (ssl), 0 = right (ssr).

Behaviour:
- Reset (reset_n low, asynchronous assert): all synchroniser flops, counters, btn_level, btn_press, btn_release, any_press and dir go to 0.
- Reset release is synchronous to the clock.
- A button held during reset reports its press only after the normal debounce latency. It is not reported at the first cycle.
- Synchroniser: 2-flop chain per button. sync[i] is btn_raw[i] delayed by 2 edges.
- Counter per button, width $clog2(DEBOUNCE_CYCLES):
  - sync[i] == btn_level[i]: counter <= 0.
  - sync[i] != btn_level[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync[i] != btn_level[i] and counter == DEBOUNCE_CYCLES-1: on that edge btn_level[i] <= sync[i] and counter <= 0.
- Any single cycle where sync matches btn_level again (a bounce) restarts the count from 0.
- Latency: a clean pin step reaches btn_level exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples the new value.
- Pulses:
  - btn_press[i] is registered. It is high for exactly the one cycle in which btn_level[i] first reads 1, and low otherwise.
  - btn_release[i] behaves the same way for 1->0.
  - press and release for the same button can never be high in the same cycle.
- any_press is registered and aligned with btn_press.
- Direction register:
  - Updates on the same edge that raises the corresponding btn_press.
  - btn_press[1] alone sets dir = 1. btn_press[0] alone sets dir = 0.
  - Both in the same cycle: dir holds.
  - Presses of btn[2..NBTN-1] and all releases: no effect on dir.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-count discards all partial counts.
- No glitch path: every output comes directly from a flop.

Decomposition:
- Package btn_pkg:
  - Index constants BTN_RIGHT = 0 and BTN_LEFT = 1.
  - Direction constants DIR_RIGHT = 1'b0 and DIR_LEFT = 1'b1.
  - Default DEBOUNCE_CYCLES value.
- Sub-module debounce_cell: one button, containing the synchroniser, counter, level, press and release logic.
- btn_debounce instantiates NBTN cells in a generate loop and adds any_press and the dir register.

Test Plan:
(Bench uses DEBOUNCE_CYCLES = 4, NBTN = 2.)
1. Clean press: btn_raw[1] 0->1 and held -> btn_level[1] rises 6 edges later. btn_press[1] and any_press are high for exactly 1 cycle on that edge. dir becomes 1 on that same edge.
2. Bounce: btn_raw[0] toggles 1,0,1,0,1 every cycle, then holds 1 -> no pulse during bouncing. btn_level[0] rises 6 edges after the final 0->1 sample. dir becomes 0.
3. Short glitch: btn_raw[1] high for 3 cycles only -> btn_level, btn_press and dir unchanged. Counter back to 0.
4. Simultaneous: btn_raw = 2'b11 on the same edge, held -> btn_press = 2'b11 in the same cycle. any_press = 1 for one cycle. dir keeps its prior value.
5. Release: with btn_level[1] = 1, btn_raw[1] -> 0 -> btn_release[1] pulses once 6 edges later. dir unchanged.
6. Reset mid-count: assert reset_n = 0 two cycles into a press, release reset with the pin still high -> all outputs 0 immediately on assert. A full 6-edge latency is counted from the first post-reset edge before btn_press.
